// File: rtl/misao_mem_pkg.sv
// Shared definitions for the misao memory responder.
// - ADDR_W_DEF : default CPU byte-address width
// - state_e    : responder phase LOAD -> RELEASE -> RUN (legacy encodings kept)
package misao_mem_pkg;

  localparam int ADDR_W_DEF = 15;

  localparam logic [1:0] S_LOAD    = 2'd0;
  localparam logic [1:0] S_RELEASE = 2'd1;
  localparam logic [1:0] S_RUN     = 2'd2;

  typedef enum logic [1:0] {
    ST_LOAD    = S_LOAD,
    ST_RELEASE = S_RELEASE,
    ST_RUN     = S_RUN
  } state_e;

endpackage

// File: rtl/misao_mem_responder_if.sv
// CPU byte port plus boot-loader stream of the misao memory responder.
// - CPU side  : mem_enable_read/_write, mem_addr, mem_rw, mem_data_out -> mem_data_in
// - Loader    : load_valid, load_data, load_last -> load_ready
// - master    : CPU / loader driver view
// - slave     : memory responder view
interface misao_mem_responder_if import misao_mem_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              mem_enable_read;
  logic              mem_enable_write;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rw;
  logic [7:0]        mem_data_out;
  logic [7:0]        mem_data_in;
  logic              load_valid;
  logic [7:0]        load_data;
  logic              load_last;
  logic              load_ready;

  modport master (
    output mem_enable_read, mem_enable_write, mem_addr, mem_rw, mem_data_out,
    output load_valid, load_data, load_last,
    input  mem_data_in, load_ready
  );

  modport slave (
    input  mem_enable_read, mem_enable_write, mem_addr, mem_rw, mem_data_out,
    input  load_valid, load_data, load_last,
    output mem_data_in, load_ready
  );
endinterface

// File: rtl/misao_byte_ram.sv
// DEPTH x 8 byte RAM: asynchronous read, single synchronous write port.
// - clk     : write clock
// - we_i    : write enable
// - waddr_i : write address,  wdata_i : write byte
// - raddr_i : read address,   rdata_o : read byte (combinational)
// Contents are not reset.
module misao_byte_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/misao_mem_responder.sv
// Memory-side responder for the misao CPU byte port.
// Boot-loads a program into on-chip RAM while holding the CPU in reset,
// then serves zero-latency reads and posted writes.
// - clk, rst  : clock, synchronous active-low reset
// - bus       : CPU byte port + loader stream (slave view)
// - cpu_rst   : active-high reset to the CPU
// - load_done : high in RUN
// - err_oob   : sticky flag, out-of-range CPU access seen
module misao_mem_responder import misao_mem_pkg::*; #(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DEPTH     = 256,
  parameter int LOAD_BASE = 0,
  parameter int BOOT_SKIP = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  misao_mem_responder_if.slave  bus,
  output logic                  cpu_rst,
  output logic                  load_done,
  output logic                  err_oob
);

  localparam int                AW      = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);

  state_e          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic            err_q, err_d;

  logic            ram_we;
  logic [AW-1:0]   ram_waddr;
  logic [7:0]      ram_wdata;
  logic [7:0]      ram_rdata;
  logic            in_range;
  logic            load_ready_w;
  logic            unused_rw;

  // Direction flag is informational only; the strobes decide.
  assign unused_rw = bus.mem_rw;

  assign in_range = ({1'b0, bus.mem_addr} < DEPTH_X);

  // Outputs are qualified with rst so the reset values appear while rst
  // is held low, not only after the state register has been cleared.
  assign load_ready_w    = rst && (state_q == ST_LOAD);
  assign bus.load_ready  = load_ready_w;
  assign cpu_rst         = !rst || (state_q != ST_RUN);
  assign load_done       = rst && (state_q == ST_RUN);
  assign err_oob         = err_q;
  assign bus.mem_data_in = (rst && (state_q == ST_RUN) && bus.mem_enable_read && in_range)
                         ? ram_rdata : '0;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    err_d     = err_q;
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    case (state_q)
      ST_LOAD: begin
        if (bus.load_valid && load_ready_w) begin
          ram_we    = 1'b1;
          ram_waddr = ptr_q;
          ram_wdata = bus.load_data;
          ptr_d     = ptr_q + AW'(1);
          if (bus.load_last || (ptr_q == AW'(DEPTH-1))) state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: state_d = ST_RUN;
      ST_RUN: begin
        if (bus.mem_enable_write && in_range) begin
          ram_we    = 1'b1;
          ram_waddr = bus.mem_addr[AW-1:0];
          ram_wdata = bus.mem_data_out;
        end
        if ((bus.mem_enable_read || bus.mem_enable_write) && !in_range) err_d = 1'b1;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= (BOOT_SKIP != 0) ? ST_RUN : ST_LOAD;
      ptr_q   <= AW'(LOAD_BASE);
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end

  misao_byte_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (bus.mem_addr[AW-1:0]),
    .rdata_o (ram_rdata)
  );

endmodule
